ipf_stream3x3: RTL and testbench

- Parametrised successor to the team's fixed 256x256 3x3 image filter.
- Reads a grayscale frame from pixel memory in raster order, exactly one read per pixel, and keeps two line buffers.
- Emits one filtered pixel for every image position, including the borders, with selectable zero or replicate border fill.
- Sits between the gray-image memory and the filtered-image write port; started per frame by a start pulse.

---
 rtl/ipf_stream3x3_if.sv | 30 +++
 rtl/ipf_stream3x3.sv | 223 ++++++++++++++++++++++
 tb/tb_ipf_stream3x3.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ipf_stream3x3_if.sv
// Bus bundle for the streaming 3x3 filter: frame control, gray-memory read port
// and filtered-pixel write port.
interface ipf_stream3x3_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = DATA_W + 2,
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic [1:0]        mode;
  logic              border;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [DATA_W-1:0] gray_data;
  logic              ipf_valid;
  logic [ADDR_W-1:0] ipf_addr;
  logic [OUT_W-1:0]  ipf_data;
  logic              busy;
  logic              done;

  // master: the filter engine; slave: frame controller and memories around it
  modport master (
    input  start, mode, border, gray_ready, gray_data,
    output gray_req, gray_addr, ipf_valid, ipf_addr, ipf_data, busy, done
  );
  modport slave (
    output start, mode, border, gray_ready, gray_data,
    input  gray_req, gray_addr, ipf_valid, ipf_addr, ipf_data, busy, done
  );
endinterface

// File: rtl/ipf_stream3x3.sv
// Streaming 3x3 image filter: one raster read per pixel, two line buffers,
// one output per pixel with zero or replicate border fill.
module ipf_stream3x3 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = DATA_W + 2,
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned ADDR_W = 16
) (
  input logic             clk,
  input logic             rst,
  ipf_stream3x3_if.master bus
);
  localparam int unsigned AH = ADDR_W / 2;
  localparam int unsigned CW = AH + 1;
  localparam int unsigned IW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned SW = DATA_W + 4;
  localparam logic [CW-1:0] W_END  = CW'(IMG_W);
  localparam logic [CW-1:0] H_END  = CW'(IMG_H);
  localparam logic [CW-1:0] W_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] H_LAST = CW'(IMG_H - 1);
  localparam logic signed [SW-1:0] S_MAX = SW'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [SW-1:0] S_MIN = ~S_MAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              flush_q, flush_d;
  logic [CW-1:0]     r_q, r_d, c_q, c_d;
  logic [1:0]        mode_q, mode_d;
  logic              border_q, border_d;
  logic              real_c, adv_c, gray_req_c;
  logic              s1_adv_q, s1_real_q;
  logic [CW-1:0]     s1_r_q, s1_c_q, cr_c, cc_c;
  logic              busy_q, done_q, ipf_valid_q, emit_c;
  logic [OUT_W-1:0]  ipf_data_q, sat_c;
  logic [ADDR_W-1:0] ipf_addr_q;
  logic [DATA_W-1:0] lb_a [IMG_W];
  logic [DATA_W-1:0] lb_b [IMG_W];
  logic [DATA_W-1:0] w0_q [3];
  logic [DATA_W-1:0] w1_q [3];
  logic [DATA_W-1:0] col_c [3];
  logic [DATA_W-1:0] raw_c [3][3];
  logic [DATA_W-1:0] rfix_c [3][3];
  logic [DATA_W-1:0] tap_c [3][3];
  logic signed [SW-1:0] acc_c;
  logic top_out_c, bot_out_c, left_out_c, right_out_c;

  // Scan control: real steps wait for gray_ready, virtual steps run freely
  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    r_d        = r_q;
    c_d        = c_q;
    mode_d     = mode_q;
    border_d   = border_q;
    real_c     = (r_q < H_END) && (c_q < W_END);
    adv_c      = 1'b0;
    gray_req_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          mode_d   = bus.mode;
          border_d = bus.border;
          r_d      = '0;
          c_d      = '0;
        end
      end
      S_RUN: begin
        adv_c      = real_c ? bus.gray_ready : 1'b1;
        gray_req_c = real_c && bus.gray_ready;
        if (adv_c) begin
          if (c_q == W_END) begin
            c_d = '0;
            if (r_q == H_END) begin
              r_d     = '0;
              flush_d = 1'b0;
              state_d = S_FLUSH;
            end else begin
              r_d = r_q + CW'(1);
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cr_c   = s1_r_q - CW'(1);
  assign cc_c   = s1_c_q - CW'(1);
  assign emit_c = s1_adv_q && (s1_r_q != '0) && (s1_c_q != '0);
  assign top_out_c   = (cr_c == '0);
  assign bot_out_c   = (cr_c == H_LAST);
  assign left_out_c  = (cc_c == '0);
  assign right_out_c = (cc_c == W_LAST);

  // Incoming column: two buffered rows above plus the returned beat (0 when virtual)
  always_comb begin
    col_c[0] = '0;
    col_c[1] = '0;
    col_c[2] = '0;
    if (s1_c_q < W_END) begin
      col_c[0] = lb_b[IW'(s1_c_q)];
      col_c[1] = lb_a[IW'(s1_c_q)];
      if (s1_real_q) col_c[2] = bus.gray_data;
    end
  end

  // Border fill: fix rows first, then columns, so corners clamp on both axes
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      raw_c[i][0] = w0_q[i];
      raw_c[i][1] = w1_q[i];
      raw_c[i][2] = col_c[i];
    end
    for (int j = 0; j < 3; j++) begin
      rfix_c[1][j] = raw_c[1][j];
      rfix_c[0][j] = top_out_c ? (border_q ? raw_c[1][j] : '0) : raw_c[0][j];
      rfix_c[2][j] = bot_out_c ? (border_q ? raw_c[1][j] : '0) : raw_c[2][j];
    end
    for (int i = 0; i < 3; i++) begin
      tap_c[i][1] = rfix_c[i][1];
      tap_c[i][0] = left_out_c  ? (border_q ? rfix_c[i][1] : '0) : rfix_c[i][0];
      tap_c[i][2] = right_out_c ? (border_q ? rfix_c[i][1] : '0) : rfix_c[i][2];
    end
  end

  function automatic logic signed [SW-1:0] shx(input logic [DATA_W-1:0] x,
                                               input int unsigned n);
    return $signed(SW'(x >> n));
  endfunction

  always_comb begin
    case (mode_q)
      2'd0: acc_c = shx(tap_c[1][2], 1) - shx(tap_c[1][0], 1);
      2'd1: acc_c = shx(tap_c[1][1], 0)
                  - (shx(tap_c[0][0], 3) + shx(tap_c[0][1], 3) + shx(tap_c[0][2], 3)
                   + shx(tap_c[1][0], 3) + shx(tap_c[1][2], 3)
                   + shx(tap_c[2][0], 3) + shx(tap_c[2][1], 3) + shx(tap_c[2][2], 3));
      2'd2: acc_c = (shx(tap_c[0][0], 4) + shx(tap_c[0][2], 4)
                   + shx(tap_c[2][0], 4) + shx(tap_c[2][2], 4))
                  + (shx(tap_c[0][1], 3) + shx(tap_c[2][1], 3)
                   + shx(tap_c[1][0], 3) + shx(tap_c[1][2], 3))
                  + shx(tap_c[1][1], 2);
      default: acc_c = shx(tap_c[1][1], 0);
    endcase
    if (acc_c > S_MAX)      sat_c = OUT_W'(S_MAX);
    else if (acc_c < S_MIN) sat_c = OUT_W'(S_MIN);
    else                    sat_c = OUT_W'(acc_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flush_q     <= 1'b0;
      r_q         <= '0;
      c_q         <= '0;
      mode_q      <= '0;
      border_q    <= 1'b0;
      s1_adv_q    <= 1'b0;
      s1_real_q   <= 1'b0;
      s1_r_q      <= '0;
      s1_c_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ipf_valid_q <= 1'b0;
      ipf_data_q  <= '0;
      ipf_addr_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        w0_q[i] <= '0;
        w1_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      r_q         <= r_d;
      c_q         <= c_d;
      mode_q      <= mode_d;
      border_q    <= border_d;
      s1_adv_q    <= adv_c;
      s1_real_q   <= real_c;
      s1_r_q      <= r_q;
      s1_c_q      <= c_q;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      ipf_valid_q <= emit_c;
      if (emit_c) begin
        ipf_data_q <= sat_c;
        ipf_addr_q <= ADDR_W'({cr_c[AH-1:0], cc_c[AH-1:0]});
      end
      if (s1_adv_q) begin
        for (int i = 0; i < 3; i++) begin
          w0_q[i] <= w1_q[i];
          w1_q[i] <= col_c[i];
        end
      end
    end
  end

  // Line buffers need no reset: stale rows are always hidden by the border fill
  always_ff @(posedge clk) begin
    if (s1_adv_q && s1_real_q) begin
      lb_b[IW'(s1_c_q)] <= lb_a[IW'(s1_c_q)];
      lb_a[IW'(s1_c_q)] <= col_c[2];
    end
  end

  assign bus.gray_req  = gray_req_c;
  assign bus.gray_addr = ADDR_W'({r_q[AH-1:0], c_q[AH-1:0]});
  assign bus.ipf_valid = ipf_valid_q;
  assign bus.ipf_addr  = ipf_addr_q;
  assign bus.ipf_data  = ipf_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_ipf_stream3x3.sv
// Bench for ipf_stream3x3 on a 4x4 frame: random images and ready toggling
// checked against a direct tap-level model of the filter.
`timescale 1ns/1ps
module tb_ipf_stream3x3;
  localparam int W = 4, H = 4, DW = 8, OW = 10, AW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ipf_stream3x3_if #(.DATA_W(DW), .OUT_W(OW), .ADDR_W(AW)) bus ();
  ipf_stream3x3 #(.DATA_W(DW), .OUT_W(OW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int img [W*H];
  int reads [W*H];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, viol = 0;
  bit rnd_ready = 1'b0;
  int cap_a[$], cap_d[$], cap_cyc[$];

  always @(posedge clk) cyc++;

  // Gray memory: one-cycle read latency, counts reads per pixel
  always @(posedge clk) begin
    int row, col;
    if (!rst && bus.gray_req) begin
      row = int'(bus.gray_addr[15:8]);
      col = int'(bus.gray_addr[7:0]);
      if (row < H && col < W) begin
        bus.gray_data <= DW'(img[row*W+col]);
        reads[row*W+col]++;
      end else begin
        viol++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus.gray_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gray_req && !bus.gray_ready) viol++;
      if (bus.ipf_valid) begin
        cap_a.push_back(int'(bus.ipf_addr));
        cap_d.push_back(int'($signed(bus.ipf_data)));
        cap_cyc.push_back(cyc);
      end
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int px(input int r, input int c, input bit b);
    int rr, cc;
    if (r < 0 || r >= H || c < 0 || c >= W) begin
      if (!b) return 0;
    end
    rr = (r < 0) ? 0 : ((r >= H) ? H-1 : r);
    cc = (c < 0) ? 0 : ((c >= W) ? W-1 : c);
    return img[rr*W+cc];
  endfunction

  function automatic int model(input int r, input int c, input int m, input bit b);
    int n, s, e, w, ne, nw, se, sw, ce, v;
    n  = px(r-1, c, b);   s  = px(r+1, c, b);
    e  = px(r, c+1, b);   w  = px(r, c-1, b);
    nw = px(r-1, c-1, b); ne = px(r-1, c+1, b);
    sw = px(r+1, c-1, b); se = px(r+1, c+1, b);
    ce = px(r, c, b);
    case (m)
      0: v = (e >> 1) - (w >> 1);
      1: v = ce - ((n>>3) + (s>>3) + (e>>3) + (w>>3) + (nw>>3) + (ne>>3) + (sw>>3) + (se>>3));
      2: v = ((nw>>4) + (ne>>4) + (sw>>4) + (se>>4)) + ((n>>3) + (s>>3) + (e>>3) + (w>>3)) + (ce>>2);
      default: v = ce;
    endcase
    if (v > 511) v = 511;
    if (v < -512) v = -512;
    return v;
  endfunction

  task automatic run_frame(input int m, input bit b, input bit rr, input string tag);
    int cnt, dcyc, bad;
    cap_a.delete(); cap_d.delete(); cap_cyc.delete();
    foreach (reads[i]) reads[i] = 0;
    viol = 0;
    rnd_ready = rr;
    @(negedge clk); bus.start = 1'b1; bus.mode = 2'(m); bus.border = b;
    @(negedge clk); bus.start = 1'b0; bus.mode = 2'($urandom); bus.border = 1'($urandom);
    @(negedge clk); bus.start = 1'b1; bus.mode = 2'($urandom);
    @(negedge clk); bus.start = 1'b0;
    cnt = 0;
    while (!bus.done && cnt < 2000) begin @(negedge clk); cnt++; end
    check_val({tag, ".done"}, int'(bus.done), 1);
    dcyc = cyc;
    bus.start = 1'b1; bus.mode = 2'd3;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk);
    check_val({tag, ".start_at_done"}, int'(bus.busy), 0);
    check_val({tag, ".count"}, cap_a.size(), W*H);
    if (cap_a.size() > 0) check_val({tag, ".done_lat"}, dcyc - cap_cyc[$], 1);
    for (int i = 0; i < W*H && i < cap_a.size(); i++) begin
      check_val($sformatf("%s.addr%0d", tag, i), cap_a[i], ((i / W) << 8) | (i % W));
      check_val($sformatf("%s.data%0d", tag, i), cap_d[i], model(i / W, i % W, m, b));
    end
    bad = 0;
    foreach (reads[i]) if (reads[i] != 1) bad++;
    check_val({tag, ".reads_once"}, bad, 0);
    check_val({tag, ".req_wo_ready"}, viol, 0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 2'd0; bus.border = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst.valid", int'(bus.ipf_valid), 0);
    check_val("rst.busy",  int'(bus.busy), 0);
    check_val("rst.done",  int'(bus.done), 0);
    check_val("rst.req",   int'(bus.gray_req), 0);
    check_val("rst.data",  int'(bus.ipf_data), 0);
    check_val("rst.addr",  int'(bus.ipf_addr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (img[i]) img[i] = 100;
    run_frame(2, 1'b1, 1'b0, "c100_m2_rep");
    if (cap_d.size() > 5) check_val("c100_m2_rep.const", cap_d[5], 97);
    run_frame(2, 1'b0, 1'b0, "c100_m2_zero");
    if (cap_d.size() > 5) begin
      check_val("c100_m2_zero.corner", cap_d[0], 55);
      check_val("c100_m2_zero.edge",   cap_d[1], 73);
      check_val("c100_m2_zero.inner",  cap_d[5], 97);
    end
    run_frame(1, 1'b1, 1'b0, "c100_m1_rep");
    run_frame(1, 1'b0, 1'b0, "c100_m1_zero");
    if (cap_d.size() > 5) begin
      check_val("c100_m1_zero.corner", cap_d[0], 64);
      check_val("c100_m1_zero.inner",  cap_d[5], 4);
    end

    foreach (img[i]) img[i] = 10 * (i % W);
    run_frame(0, 1'b1, 1'b0, "ramp_m0");
    if (cap_d.size() > 3) begin
      check_val("ramp_m0.col0", cap_d[0], 5);
      check_val("ramp_m0.col1", cap_d[1], 10);
      check_val("ramp_m0.col2", cap_d[2], 10);
      check_val("ramp_m0.col3", cap_d[3], 5);
    end
    run_frame(3, 1'b1, 1'b1, "ramp_m3");

    for (int k = 0; k < 4; k++) begin
      int m;
      bit b;
      foreach (img[i]) img[i] = (k == 3) ? (($urandom_range(0, 1) != 0) ? 255 : 0)
                                         : int'($urandom_range(0, 255));
      m = int'($urandom_range(0, 3));
      b = 1'($urandom_range(0, 1));
      run_frame(m, b, 1'b1, $sformatf("rnd%0d_ready_rand", k));
      run_frame(m, b, 1'b0, $sformatf("rnd%0d_ready_hi", k));
    end

    // Abort a frame mid row 2, then run a fresh frame on a new image
    foreach (img[i]) img[i] = int'($urandom_range(0, 255));
    rnd_ready = 1'b1;
    @(negedge clk); bus.start = 1'b1; bus.mode = 2'd0; bus.border = 1'b0;
    @(negedge clk); bus.start = 1'b0;
    cnt = 0;
    while (!(bus.gray_req && bus.gray_addr == 16'h0201) && cnt < 500) begin
      @(negedge clk); cnt++;
    end
    check_val("abort.reached_row2", int'(bus.gray_addr), 'h0201);
    rst = 1'b1;
    #1;
    check_val("abort.busy",  int'(bus.busy), 0);
    check_val("abort.valid", int'(bus.ipf_valid), 0);
    check_val("abort.req",   int'(bus.gray_req), 0);
    @(negedge clk); rst = 1'b0;
    foreach (img[i]) img[i] = int'($urandom_range(0, 255));
    run_frame(2, 1'b0, 1'b1, "after_rst_m2");
    foreach (img[i]) img[i] = int'($urandom_range(0, 255));
    run_frame(1, 1'b1, 1'b1, "after_rst_m1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
